regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 35 +++
 rtl/wb_slot.sv | 81 ++++++++
 rtl/regfile_wb_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared widths, constants and types for the register-file writeback
//   arbiter and its per-requester slot.
//
//   REG_ADDR_W   : register index width (32 architectural registers)
//   DATA_W       : register data width
//   ZERO_REG     : index of the hardwired-zero register
//   slot_state_e : occupancy of a one-entry writeback slot
//   req_sel_e    : identifies requester A or B (round-robin pointer value)
//   wb_entry_t   : one buffered write (destination register + data)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } req_sel_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wreg;
        logic [DATA_W-1:0]     wdata;
    } wb_entry_t;

endpackage : regfile_pkg

// File: rtl/wb_slot.sv
// -----------------------------------------------------------------------------
// wb_slot
//   One-entry writeback buffer owned by a single requester. The slot accepts a
//   write when it is empty, or when it is full and its entry is being granted
//   to the register file this cycle (so a busy requester keeps one write per
//   cycle flowing). Writes to the zero register are swallowed on acceptance.
//
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   valid_i  in   requester presents a write
//   ready_o  out  slot can take a write this cycle (no path from valid_i)
//   reg_i    in   destination register of the presented write
//   data_i   in   data of the presented write
//   grant_i  in   arbiter drains this slot's entry at the coming edge
//   full_o   out  slot holds a buffered write
//   fill_o   out  a write is being captured into the slot at the coming edge
//   reg_o    out  destination register of the buffered write
//   data_o   out  data of the buffered write
// -----------------------------------------------------------------------------
module wb_slot
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [REG_ADDR_W-1:0] reg_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  grant_i,
    output logic                  full_o,
    output logic                  fill_o,
    output logic [REG_ADDR_W-1:0] reg_o,
    output logic [DATA_W-1:0]     data_o
);

    slot_state_e state_q, state_d;
    wb_entry_t   entry_q, entry_d;
    logic        accept;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch can be inferred.
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;

        // grant_i is derived from slot state only, so ready_o never depends
        // on any valid input.
        ready_o = (state_q == EMPTY) || grant_i;
        accept  = valid_i && ready_o;
        fill_o  = accept && (reg_i != ZERO_REG);

        if (fill_o) begin
            // Capture wins over drain: a granted entry is replaced in place.
            state_d = FULL;
            entry_d = '{wreg: reg_i, wdata: data_i};
        end else if (grant_i) begin
            // Covers plain drains and drains paired with an r0 write, which is
            // accepted but never stored.
            state_d = EMPTY;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    // The entry is reset along with the state; it is a single word, and a
    // defined value keeps the read-back ports free of X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

    assign full_o = (state_q == FULL);
    assign reg_o  = entry_q.wreg;
    assign data_o = entry_q.wdata;

endmodule : wb_slot

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Merges two writeback streams (A: ALU, B: multdiv) onto the single write
//   port of the register file. Each stream owns a one-entry slot; at most one
//   slot is drained per cycle into the registered write port.
//
//   Arbitration when both slots are full:
//     - same destination register : the older entry goes first (age bit)
//     - different registers       : RR_EN=1 round-robin, RR_EN=0 A first
//   A lone full slot is always granted.
//
//   Parameters
//     RR_EN           1 = round-robin, 0 = fixed priority to A
//   Ports
//     clock           in   single clock, rising edge
//     ctrl_reset_n    in   asynchronous active-low reset
//     a_valid/b_valid in   requester presents a write
//     a_ready/b_ready out  requester's slot can accept this cycle
//     a_reg/b_reg     in   destination register
//     a_data/b_data   in   write data
//     rf_writeEnable  out  register-file write strobe (registered)
//     rf_writeReg     out  register-file write index (registered)
//     rf_writeData    out  register-file write data  (registered)
//     q_reg           in   hazard-query register index
//     q_pending       out  q_reg has a write still in flight (combinational)
//     busy            out  any slot full or a write on the port
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0]     a_data,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0]     b_data,

    output logic                  rf_writeEnable,
    output logic [REG_ADDR_W-1:0] rf_writeReg,
    output logic [DATA_W-1:0]     rf_writeData,

    input  logic [REG_ADDR_W-1:0] q_reg,
    output logic                  q_pending,
    output logic                  busy
);

    // Slot-side signals
    logic                  a_full, b_full;
    logic                  a_fill, b_fill;
    logic [REG_ADDR_W-1:0] a_wreg, b_wreg;
    logic [DATA_W-1:0]     a_wdata, b_wdata;
    logic                  grant_a, grant_b;

    // Arbiter state
    req_sel_e              rr_q, rr_d;           // requester favoured on the next contested grant
    logic                  b_older_q, b_older_d; // B holds the older entry when both are full
    logic                  a_stay, b_stay;

    // Write port
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_reg_q, rf_reg_d;
    logic [DATA_W-1:0]     rf_data_q, rf_data_d;

    wb_slot u_slot_a (
        .clk     (clock),
        .rst_n   (ctrl_reset_n),
        .valid_i (a_valid),
        .ready_o (a_ready),
        .reg_i   (a_reg),
        .data_i  (a_data),
        .grant_i (grant_a),
        .full_o  (a_full),
        .fill_o  (a_fill),
        .reg_o   (a_wreg),
        .data_o  (a_wdata)
    );

    wb_slot u_slot_b (
        .clk     (clock),
        .rst_n   (ctrl_reset_n),
        .valid_i (b_valid),
        .ready_o (b_ready),
        .reg_i   (b_reg),
        .data_i  (b_data),
        .grant_i (grant_b),
        .full_o  (b_full),
        .fill_o  (b_fill),
        .reg_o   (b_wreg),
        .data_o  (b_wdata)
    );

    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        rr_d      = rr_q;
        b_older_d = b_older_q;
        rf_we_d   = 1'b0;
        rf_reg_d  = rf_reg_q;
        rf_data_d = rf_data_q;

        // Grant: slot occupancy, entry registers and arbiter state only.
        case ({a_full, b_full})
            2'b10: grant_a = 1'b1;
            2'b01: grant_b = 1'b1;
            2'b11: begin
                if (a_wreg == b_wreg) begin
                    // Same destination: program order must be preserved.
                    grant_b = b_older_q;
                    grant_a = !b_older_q;
                end else if (RR_EN && (rr_q == SEL_B)) begin
                    grant_b = 1'b1;
                end else begin
                    grant_a = 1'b1;
                end
            end
            default: ;
        endcase

        // The pointer only moves on contested grants.
        if (a_full && b_full) begin
            rr_d = grant_a ? SEL_B : SEL_A;
        end

        // Age: an entry kept in its slot is older than one captured beside it;
        // simultaneous captures treat A as older.
        a_stay = a_full && !grant_a;
        b_stay = b_full && !grant_b;
        if (a_fill && b_fill) begin
            b_older_d = 1'b0;
        end else if (a_stay && b_fill) begin
            b_older_d = 1'b0;
        end else if (b_stay && a_fill) begin
            b_older_d = 1'b1;
        end

        // Write port: load on grant, otherwise drop the strobe and hold.
        if (grant_a) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = a_wreg;
            rf_data_d = a_wdata;
        end else if (grant_b) begin
            rf_we_d   = 1'b1;
            rf_reg_d  = b_wreg;
            rf_data_d = b_wdata;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            rr_q      <= SEL_A;
            b_older_q <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_reg_q  <= ZERO_REG;
            rf_data_q <= '0;
        end else begin
            rr_q      <= rr_d;
            b_older_q <= b_older_d;
            rf_we_q   <= rf_we_d;
            rf_reg_q  <= rf_reg_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_writeEnable = rf_we_q;
    assign rf_writeReg    = rf_reg_q;
    assign rf_writeData   = rf_data_q;

    assign busy = a_full || b_full || rf_we_q;

    // r0 never reads as pending: it is never stored and never written.
    assign q_pending = (q_reg != ZERO_REG) &&
                       ((a_full  && (a_wreg   == q_reg)) ||
                        (b_full  && (b_wreg   == q_reg)) ||
                        (rf_we_q && (rf_reg_q == q_reg)));

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Drives one fixed-priority and one round-robin instance with the same
//   stimulus and compares both against a transaction-level model: each slot
//   is a buffered write stamped with an acceptance sequence number, and the
//   grant is picked by the arbitration rules (oldest for equal registers,
//   then policy). Directed steps add cycle-exact expectations.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        ctrl_reset_n;
    logic        a_valid, b_valid;
    logic [4:0]  a_reg, b_reg, q_reg;
    logic [31:0] a_data, b_data;

    // index 0: RR_EN=0 (fixed), index 1: RR_EN=1 (round-robin)
    logic [1:0]  a_ready_w, b_ready_w, we_w, qp_w, busy_w;
    logic [4:0]  wreg_w  [2];
    logic [31:0] wdata_w [2];

    regfile_wb_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .a_valid(a_valid), .a_ready(a_ready_w[0]), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready_w[0]), .b_reg(b_reg), .b_data(b_data),
        .rf_writeEnable(we_w[0]), .rf_writeReg(wreg_w[0]), .rf_writeData(wdata_w[0]),
        .q_reg(q_reg), .q_pending(qp_w[0]), .busy(busy_w[0])
    );

    regfile_wb_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .a_valid(a_valid), .a_ready(a_ready_w[1]), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready_w[1]), .b_reg(b_reg), .b_data(b_data),
        .rf_writeEnable(we_w[1]), .rf_writeReg(wreg_w[1]), .rf_writeData(wdata_w[1]),
        .q_reg(q_reg), .q_pending(qp_w[1]), .busy(busy_w[1])
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          full;
        logic [4:0]  r;
        logic [31:0] d;
        int unsigned seq;
    } mslot_t;

    mslot_t      ms [2][2];   // [policy][requester]
    bit          m_we    [2];
    logic [4:0]  m_wreg  [2];
    logic [31:0] m_wdata [2];
    int          m_last  [2]; // requester granted last while both were full
    int unsigned m_ctr   [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic m_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 2; i++) ms[p][i] = '{1'b0, 5'd0, 32'd0, 0};
            m_we[p]    = 1'b0;
            m_wreg[p]  = 5'd0;
            m_wdata[p] = 32'd0;
            m_last[p]  = 1;   // so A wins the first contest
            m_ctr[p]   = 0;
        end
    endtask

    function automatic int m_pick(int p);
        if (ms[p][0].full && ms[p][1].full) begin
            if (ms[p][0].r == ms[p][1].r) return (ms[p][0].seq < ms[p][1].seq) ? 0 : 1;
            if (p == 1) return 1 - m_last[p];
            return 0;
        end
        if (ms[p][0].full) return 0;
        if (ms[p][1].full) return 1;
        return -1;
    endfunction

    function automatic bit m_ready(int p, int i);
        return !ms[p][i].full || (m_pick(p) == i);
    endfunction

    function automatic bit m_busy(int p);
        return ms[p][0].full || ms[p][1].full || m_we[p];
    endfunction

    function automatic bit m_qp(int p, logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        return (ms[p][0].full && ms[p][0].r == q) ||
               (ms[p][1].full && ms[p][1].r == q) ||
               (m_we[p] && m_wreg[p] == q);
    endfunction

    task automatic m_advance();
        for (int p = 0; p < 2; p++) begin
            int g    = m_pick(p);
            bit both = ms[p][0].full && ms[p][1].full;
            bit ra   = m_ready(p, 0);
            bit rb   = m_ready(p, 1);
            if (g >= 0) begin
                m_we[p]    = 1'b1;
                m_wreg[p]  = ms[p][g].r;
                m_wdata[p] = ms[p][g].d;
                ms[p][g].full = 1'b0;
                if (both) m_last[p] = g;
            end else begin
                m_we[p] = 1'b0;
            end
            if (a_valid && ra && a_reg != 5'd0) ms[p][0] = '{1'b1, a_reg, a_data, m_ctr[p]};
            if (b_valid && rb && b_reg != 5'd0) ms[p][1] = '{1'b1, b_reg, b_data, m_ctr[p] + 1};
            m_ctr[p] += 2;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        for (int p = 0; p < 2; p++) begin
            check($sformatf("p%0d a_ready", p), 32'(a_ready_w[p]), 32'(m_ready(p, 0)));
            check($sformatf("p%0d b_ready", p), 32'(b_ready_w[p]), 32'(m_ready(p, 1)));
            check($sformatf("p%0d busy", p),    32'(busy_w[p]),    32'(m_busy(p)));
            check($sformatf("p%0d q_pending", p), 32'(qp_w[p]),    32'(m_qp(p, q_reg)));
            check($sformatf("p%0d rf_we", p),   32'(we_w[p]),      32'(m_we[p]));
            check($sformatf("p%0d rf_reg", p),  32'(wreg_w[p]),    32'(m_wreg[p]));
            check($sformatf("p%0d rf_data", p), wdata_w[p],        m_wdata[p]);
        end
    endtask

    // One cycle: drive away from the rising edge, compare, then advance the model
    // to the state it will hold after the coming edge.
    task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                        input bit bv, input logic [4:0] br, input logic [31:0] bd,
                        input logic [4:0] qr);
        @(negedge clock);
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        q_reg   = qr;
        #1;
        check_model();
        m_advance();
    endtask

    task automatic idle(input int n, input logic [4:0] qr);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [4:0] reg_tab [5];

    initial begin
        reg_tab = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd7};
        ctrl_reset_n = 1'b0;
        a_valid = 1'b0; a_reg = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_reg = 5'd0; b_data = 32'd0;
        q_reg   = 5'd0;
        m_reset();

        // During reset
        #1;
        for (int p = 0; p < 2; p++) begin
            check("rst a_ready", 32'(a_ready_w[p]), 32'd1);
            check("rst b_ready", 32'(b_ready_w[p]), 32'd1);
            check("rst busy",    32'(busy_w[p]),    32'd0);
            check("rst q_pend",  32'(qp_w[p]),      32'd0);
            check("rst rf_we",   32'(we_w[p]),      32'd0);
            check("rst rf_reg",  32'(wreg_w[p]),    32'd0);
            check("rst rf_data", wdata_w[p],        32'd0);
        end
        repeat (2) @(negedge clock);
        ctrl_reset_n = 1'b1;
        idle(2, 5'd0);

        // Single A write: port strobe in cycle 2 only, idle from cycle 3
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);
        for (int p = 0; p < 2; p++) begin
            check("single c1 rf_we", 32'(we_w[p]), 32'd0);
            check("single c1 busy",  32'(busy_w[p]), 32'd1);
            check("single c1 q_pend", 32'(qp_w[p]), 32'd1);
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);
        for (int p = 0; p < 2; p++) begin
            check("single c2 rf_we",   32'(we_w[p]),   32'd1);
            check("single c2 rf_reg",  32'(wreg_w[p]), 32'd5);
            check("single c2 rf_data", wdata_w[p],     32'hDEADBEEF);
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5);
        for (int p = 0; p < 2; p++) begin
            check("single c3 rf_we", 32'(we_w[p]),   32'd0);
            check("single c3 busy",  32'(busy_w[p]), 32'd0);
        end
        idle(2, 5'd0);

        // Both requesters streaming: A reg 1, B reg 2
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 5'd1, 32'h100 + k, 1'b1, 5'd2, 32'h200 + k, 5'd0);
            if (k >= 2) begin
                check("stream rr rf_we",  32'(we_w[1]),   32'd1);
                check("stream rr rf_reg", 32'(wreg_w[1]), (k % 2 == 0) ? 32'd1 : 32'd2);
                check("stream fp rf_we",  32'(we_w[0]),   32'd1);
                check("stream fp rf_reg", 32'(wreg_w[0]), 32'd1);
                check("stream fp b_ready", 32'(b_ready_w[0]), 32'd0);
            end
        end
        idle(4, 5'd0);

        // Same register, B first then A: order 0x1 then 0x2 under both policies
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1, 5'd7);
        step(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0, 5'd7);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);
        for (int p = 0; p < 2; p++) begin
            check("order first we",   32'(we_w[p]), 32'd1);
            check("order first data", wdata_w[p],   32'h1);
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);
        for (int p = 0; p < 2; p++) begin
            check("order second we",   32'(we_w[p]), 32'd1);
            check("order second data", wdata_w[p],   32'h2);
        end
        idle(2, 5'd0);

        // Write to r0 is discarded
        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
            for (int p = 0; p < 2; p++) begin
                check("r0 rf_we",  32'(we_w[p]),   32'd0);
                check("r0 q_pend", 32'(qp_w[p]),   32'd0);
                check("r0 busy",   32'(busy_w[p]), 32'd0);
            end
        end

        // Randomised traffic with register collisions and r0 writes
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, reg_tab[$urandom_range(0, 4)], $urandom,
                 $urandom_range(0, 3) != 0, reg_tab[$urandom_range(0, 4)], $urandom,
                 5'($urandom_range(0, 7)));
        end
        idle(4, 5'd0);

        // Reset in the middle of a cycle with both slots full
        step(1'b1, 5'd3, 32'hAAA, 1'b1, 5'd4, 32'hBBB, 5'd4);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd4);
        for (int p = 0; p < 2; p++) check("prerst busy", 32'(busy_w[p]), 32'd1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd4);
        for (int p = 0; p < 2; p++) check("prerst rf_we", 32'(we_w[p]), 32'd1);
        #2 ctrl_reset_n = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) begin
            check("midrst rf_we",   32'(we_w[p]),      32'd0);
            check("midrst a_ready", 32'(a_ready_w[p]), 32'd1);
            check("midrst b_ready", 32'(b_ready_w[p]), 32'd1);
            check("midrst busy",    32'(busy_w[p]),    32'd0);
            check("midrst q_pend",  32'(qp_w[p]),      32'd0);
        end
        m_reset();
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd4);
            for (int p = 0; p < 2; p++) begin
                check("postrst rf_we",   32'(we_w[p]),      32'd0);
                check("postrst q_pend",  32'(qp_w[p]),      32'd0);
                check("postrst a_ready", 32'(a_ready_w[p]), 32'd1);
                check("postrst b_ready", 32'(b_ready_w[p]), 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
